pipeline_ctrl: RTL and testbench

- Central stall/flush/redirect sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into a stall vector and drives the IFID/IDEX/EXMEM/MEMWB pipeline registers.
- Turns EX branch mispredicts and MEM exceptions/eret into flush pulses plus a PC redirect for IF.
- Holds a redirect pending while IF has a fetch outstanding, so the redirect is never lost.

---
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the IF/ID/EX/MEM/WB pipeline.
// Ports: per-stage stall requests, EX mispredict, MEM exc/eret in;
// stall[4:0], flush[3:0], redirect_valid/pc, busy_redirect,
// stall_cycles out.
module pipeline_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_mispredict,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              mem_exc,
  input  logic              mem_eret,
  input  logic [ADDR_W-1:0] cp0_epc,
  output logic [4:0]        stall,
  output logic [3:0]        flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy_redirect,
  output logic [31:0]       stall_cycles
);

  typedef enum logic {
    RUN,
    WAIT_IF
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pend_pc;
  logic [ADDR_W-1:0] pend_nxt;
  logic [31:0]       cnt;

  logic [4:0]        base;
  logic [4:0]        st;
  logic [3:0]        fl;
  logic              rv;
  logic [ADDR_W-1:0] rpc;
  logic              take;
  logic              take_exc;
  logic              take_eret;
  logic              take_mis;
  logic [ADDR_W-1:0] tgt;

  // A stall at stage s freezes every older-to-younger stage below it.
  always_comb begin
    base    = '0;
    base[3] = mem_stall_req;
    base[2] = mem_stall_req | ex_stall_req;
    base[1] = base[2] | id_stall_req;
    base[0] = base[1] | if_stall_req;
  end

  // A MEM instruction stalled on the dcache has not committed yet.
  assign take      = (state == RUN) && !mem_stall_req;
  assign take_exc  = take && mem_exc;
  assign take_eret = take && !mem_exc && mem_eret;
  assign take_mis  = take && !mem_exc && !mem_eret
                     && ex_mispredict;

  always_comb begin
    tgt = ex_target;
    if (mem_exc)
      tgt = EXC_VECTOR;
    else if (mem_eret)
      tgt = cp0_epc;
  end

  always_comb begin
    st        = base;
    fl        = '0;
    rv        = 1'b0;
    rpc       = '0;
    state_nxt = state;
    pend_nxt  = pend_pc;
    if (state == RUN) begin
      if (take_exc || take_eret) begin
        st = '0;
        fl = 4'b1111;
      end else if (take_mis) begin
        st = {base[4:2], 2'b00};
        fl = 4'b0011;
      end
      if (take_exc || take_eret || take_mis) begin
        if (!if_stall_req) begin
          rv  = 1'b1;
          rpc = tgt;
        end else begin
          state_nxt = WAIT_IF;
          pend_nxt  = tgt;
        end
      end
    end else begin
      // The outstanding fetch is from the dead path.
      fl = 4'b0001;
      if (mem_exc && !mem_stall_req) begin
        st       = '0;
        fl       = 4'b1111;
        pend_nxt = EXC_VECTOR;
      end
      if (!if_stall_req) begin
        rv        = 1'b1;
        rpc       = pend_nxt;
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pend_pc <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
      if (st[0])
        cnt <= cnt + 32'd1;
    end
  end

  // Outputs are forced idle while reset is held.
  assign stall          = rst ? '0 : st;
  assign flush          = rst ? '0 : fl;
  assign redirect_valid = rst ? 1'b0 : rv;
  assign redirect_pc    = rst ? '0 : rpc;
  assign busy_redirect  = !rst && (state == WAIT_IF);
  assign stall_cycles   = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, hand sequences,
// random stimulus against an event-level reference model.
module tb_pipeline_ctrl;

  localparam logic [31:0] EXC = 32'hBFC00380;

  logic        clk;
  logic        rst;
  logic        if_stall_req;
  logic        id_stall_req;
  logic        ex_stall_req;
  logic        mem_stall_req;
  logic        ex_mispredict;
  logic [31:0] ex_target;
  logic        mem_exc;
  logic        mem_eret;
  logic [31:0] cp0_epc;
  logic [4:0]  stall;
  logic [3:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy_redirect;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .ex_stall_req   (ex_stall_req),
    .mem_stall_req  (mem_stall_req),
    .ex_mispredict  (ex_mispredict),
    .ex_target      (ex_target),
    .mem_exc        (mem_exc),
    .mem_eret       (mem_eret),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy_redirect  (busy_redirect),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic        mis;
    logic [31:0] tgt;
    logic [4:0]  st;
    logic [3:0]  fl;
    logic        rv;
    logic [31:0] pc;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // req = {mem, ex, id, if}
  task automatic drive(input logic [3:0] r, input logic mi,
                       input logic [31:0] t, input logic ex,
                       input logic er, input logic [31:0] ep);
    {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = r;
    ex_mispredict = mi;
    ex_target     = t;
    mem_exc       = ex;
    mem_eret      = er;
    cp0_epc       = ep;
    #3;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string n, input logic [4:0] s,
                         input logic [3:0] f, input logic v,
                         input logic [31:0] p, input logic b);
    chk({n, ".stall"}, 32'(stall), 32'(s));
    chk({n, ".flush"}, 32'(flush), 32'(f));
    chk({n, ".rv"}, 32'(redirect_valid), 32'(v));
    chk({n, ".pc"}, redirect_pc, p);
    chk({n, ".busy"}, 32'(busy_redirect), 32'(b));
  endtask

  // Reference model: one pending-redirect slot plus a cycle counter.
  logic        m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic model_cycle(output logic [4:0] es,
                             output logic [3:0] ef,
                             output logic ev,
                             output logic [31:0] ep);
    logic [3:0]  r;
    int          s;
    logic [31:0] target;
    bit          ev_exc;
    bit          ev_any;
    r = {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req};
    s = -1;
    for (int k = 0; k < 4; k++)
      if (r[k]) s = k;
    es = 5'((32'd1 << (s + 1)) - 1);
    ef = 4'd0;
    ev = 1'b0;
    ep = 32'd0;
    if (!m_wait) begin
      ev_exc = !mem_stall_req && (mem_exc || mem_eret);
      ev_any = ev_exc || (!mem_stall_req && ex_mispredict);
      target = mem_exc ? EXC : (mem_eret ? cp0_epc : ex_target);
      if (ev_exc) begin
        es = 5'd0;
        ef = 4'hF;
      end else if (ev_any) begin
        es = es & 5'b11100;
        ef = 4'b0011;
      end
      if (ev_any && !if_stall_req) begin
        ev = 1'b1;
        ep = target;
      end else if (ev_any) begin
        m_wait = 1'b1;
        m_pc   = target;
      end
    end else begin
      ef = 4'b0001;
      if (mem_exc && !mem_stall_req) begin
        es   = 5'd0;
        ef   = 4'hF;
        m_pc = EXC;
      end
      if (!if_stall_req) begin
        ev     = 1'b1;
        ep     = m_pc;
        m_wait = 1'b0;
      end
    end
    if (es[0]) m_cnt = m_cnt + 1;
  endtask

  initial begin
    logic [4:0]  es;
    logic [3:0]  ef;
    logic        ev;
    logic [31:0] ep;
    logic        busy_exp;
    logic [31:0] cnt_exp;

    vec[0]  = {4'b0000, 1'b0, 32'h0,         5'b00000, 4'h0, 1'b0, 32'h0};
    vec[1]  = {4'b0100, 1'b0, 32'h0,         5'b00111, 4'h0, 1'b0, 32'h0};
    vec[2]  = {4'b0100, 1'b0, 32'h0,         5'b00111, 4'h0, 1'b0, 32'h0};
    vec[3]  = {4'b0100, 1'b0, 32'h0,         5'b00111, 4'h0, 1'b0, 32'h0};
    vec[4]  = {4'b0010, 1'b0, 32'h0,         5'b00011, 4'h0, 1'b0, 32'h0};
    vec[5]  = {4'b0001, 1'b0, 32'h0,         5'b00001, 4'h0, 1'b0, 32'h0};
    vec[6]  = {4'b1000, 1'b0, 32'h0,         5'b01111, 4'h0, 1'b0, 32'h0};
    vec[7]  = {4'b0000, 1'b1, 32'h8000_0040, 5'b00000, 4'h3, 1'b1, 32'h8000_0040};
    vec[8]  = {4'b0000, 1'b0, 32'h0,         5'b00000, 4'h0, 1'b0, 32'h0};
    vec[9]  = {4'b0100, 1'b1, 32'h8000_0080, 5'b00100, 4'h3, 1'b1, 32'h8000_0080};
    vec[10] = {4'b1000, 1'b1, 32'h8000_0100, 5'b01111, 4'h0, 1'b0, 32'h0};

    rst = 1'b1;
    drive(4'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #9 rst = 1'b0;
    nxt();

    for (int i = 0; i < 10; i++) begin
      drive(4'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("idle", 5'd0, 4'd0, 1'b0, 32'h0, 1'b0);
      nxt();
    end
    chk("idle.cnt", stall_cycles, 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vec[i].req, vec[i].mis, vec[i].tgt, 1'b0, 1'b0, 32'h0);
      chk_out($sformatf("vec%0d", i), vec[i].st, vec[i].fl,
              vec[i].rv, vec[i].pc, 1'b0);
      if (i == 4) chk("vec.cnt3", stall_cycles, 32'd3);
      nxt();
    end
    chk("vec.cnt", stall_cycles, 32'd7);

    // Mispredict while IF busy, late mispredict ignored.
    drive(4'b0001, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0);
    chk_out("wmis", 5'd0, 4'h3, 1'b0, 32'h0, 1'b0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, i == 1, 32'h9000_0000, 1'b0, 1'b0, 32'h0);
      chk_out("wait", 5'b00001, 4'h1, 1'b0, 32'h0, 1'b1);
      nxt();
    end
    drive(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_out("wdone", 5'd0, 4'h1, 1'b1, 32'h8000_0040, 1'b1);
    nxt();
    drive(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_out("wrun", 5'd0, 4'h0, 1'b0, 32'h0, 1'b0);
    nxt();

    // Exception beats mispredict; dcache stall defers it.
    drive(4'b0100, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0);
    chk_out("excmis", 5'd0, 4'hF, 1'b1, EXC, 1'b0);
    nxt();
    drive(4'b1000, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0);
    chk_out("excmst", 5'b01111, 4'h0, 1'b0, 32'h0, 1'b0);
    nxt();
    drive(4'b0000, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0);
    chk_out("excgo", 5'd0, 4'hF, 1'b1, EXC, 1'b0);
    nxt();

    // Exception overrides a pending redirect.
    drive(4'b0001, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0);
    nxt();
    drive(4'b0001, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_out("wexc", 5'd0, 4'hF, 1'b0, 32'h0, 1'b1);
    nxt();
    drive(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_out("wexcgo", 5'd0, 4'h1, 1'b1, EXC, 1'b1);
    nxt();

    // eret pending, then reset drops it.
    drive(4'b0001, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_1234);
    chk_out("eret", 5'd0, 4'hF, 1'b0, 32'h0, 1'b0);
    nxt();
    drive(4'b0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_1234);
    chk_out("eretw", 5'b00001, 4'h1, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    chk_out("rst", 5'd0, 4'h0, 1'b0, 32'h0, 1'b0);
    chk("rst.cnt", stall_cycles, 32'd0);
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_1234);
      chk_out("postrst", 5'd0, 4'h0, 1'b0, 32'h0, 1'b0);
      nxt();
    end

    // Random run against the model.
    rst = 1'b1;
    #2 rst = 1'b0;
    m_wait = 1'b0;
    m_pc   = 32'd0;
    m_cnt  = 32'd0;
    for (int i = 0; i < 400; i++) begin
      drive({$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0},
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom);
      busy_exp = m_wait;
      cnt_exp  = m_cnt;
      model_cycle(es, ef, ev, ep);
      chk_out("rand", es, ef, ev, ep, busy_exp);
      chk("rand.cnt", stall_cycles, cnt_exp);
      nxt();
    end
    chk("rand.cntend", stall_cycles, m_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
